// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (output start, op, operand1, operand2, input ready, valid, result, flags);
  modport slave  (input start, op, operand1, operand2, output ready, valid, result, flags);
endinterface

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide, one bit per cycle: WIDTH+2 cycles per op, fast-path ops in one.
// Divider is built only when MULDIV_DIV_EN is defined; otherwise ops 1xx return 0 with z set.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  logic [1:0]         state;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b;
  logic               neg_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;

  logic               accept;
  logic               sgn1, sgn2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               fast;
  logic [WIDTH-1:0]   fast_res;
  logic               fast_dz, fast_ov;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fin;

`ifdef MULDIV_DIV_EN
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic               neg_r;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;
`endif

  assign bus.ready  = (state == IDLE) || (state == DONE);
  assign bus.valid  = (state == DONE);
  assign bus.result = result_q;
  assign bus.flags  = flags_q;
  assign accept     = bus.ready && bus.start;

  // Work on magnitudes; the sign is reapplied once in FINISH.
  always_comb begin
    sgn1 = bus.operand1[WIDTH-1] &
           ((bus.op == OP_MULH) || (bus.op == OP_MULHSU) || (bus.op == OP_DIV) || (bus.op == OP_REM));
    sgn2 = bus.operand2[WIDTH-1] &
           ((bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM));
    mag1 = sgn1 ? -bus.operand1 : bus.operand1;
    mag2 = sgn2 ? -bus.operand2 : bus.operand2;
  end

  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    fast_dz  = 1'b0;
    fast_ov  = 1'b0;
`ifdef MULDIV_DIV_EN
    if (bus.op[2]) begin
      if (bus.operand2 == '0) begin
        fast     = 1'b1;
        fast_dz  = 1'b1;
        fast_res = bus.op[1] ? bus.operand1 : '1;
      end else if (!bus.op[0] && (bus.operand1 == SMIN) && (bus.operand2 == '1)) begin
        fast     = 1'b1;
        fast_ov  = 1'b1;
        fast_res = bus.op[1] ? '0 : SMIN;
      end
    end
`else
    fast = bus.op[2];
`endif
  end

  // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  // Restoring step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  always_comb begin
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, b};
    div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
`endif

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    fin      = '0;
    case (op_q)
      3'b000:                 fin = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_fix[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
      3'b100, 3'b101:         fin = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      default:                fin = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`else
      default:                fin = '0;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      acc      <= '0;
      b        <= '0;
      neg_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r    <= 1'b0;
`endif
      cnt      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q  <= bus.op;
            cnt   <= '0;
            neg_q <= sgn1 ^ sgn2;
`ifdef MULDIV_DIV_EN
            neg_r <= sgn1;
`endif
            acc   <= {{WIDTH{1'b0}}, (bus.op[2] ? mag1 : mag2)};
            b     <= bus.op[2] ? mag2 : mag1;
            if (fast) begin
              result_q <= fast_res;
              flags_q  <= {fast_dz, fast_ov, (fast_res == '0), fast_res[WIDTH-1]};
              state    <= DONE;
            end else begin
              state    <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
`ifdef MULDIV_DIV_EN
          acc <= op_q[2] ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1))
            state <= FINISH;
        end
        FINISH: begin
          result_q <= fin;
          flags_q  <= {2'b00, (fin == '0), fin[WIDTH-1]};
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32) against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    longint sa, sb;
    logic [63:0] p;
    logic dz, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0; ov = 1'b0; lat = LAT; r = '0;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          lat = 0; dz = 1'b1; r = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 0; ov = 1'b1; r = op[1] ? 32'd0 : a;
        end else begin
          case (op)
            3'd4:    r = 32'(sa / sb);
            3'd5:    r = a / b;
            3'd6:    r = 32'(sa % sb);
            default: r = a % b;
          endcase
        end
`else
        lat = 0; r = '0;
`endif
      end
    endcase
    f = {dz, ov, (r == 32'd0), r[31]};
  endfunction

  // Issue one request (ready assumed high now) and wait for its valid pulse.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [3:0] fl, output int lat,
                        output bit rdy_ok, output int vcyc);
    rdy_ok = (bus.ready === 1'b1);
    bus.start = 1'b1; bus.op = o; bus.operand1 = a; bus.operand2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'($urandom); bus.operand1 = $urandom; bus.operand2 = $urandom;
    lat = -1; res = 'x; fl = 'x; vcyc = 0;
    for (int n = 0; n <= 100; n++) begin
      if (bus.valid === 1'b1) begin
        lat = n; res = bus.result; fl = bus.flags; vcyc = cyc;
        break;
      end
      if (bus.ready !== 1'b0) rdy_ok = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = '0; bus.operand1 = '0; bus.operand2 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", bus.flags); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_latency();
    logic [31:0] res; logic [3:0] fl; int lat, vc; bit rok;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, fl, lat, rok, vc);
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
    checks++; if (fl !== 4'b0001) begin errors++; $display("FAIL mul_flags: got %b expected 0001", fl); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL mul_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (!rok) begin errors++; $display("FAIL mul_ready_busy: got ready high while busy, expected low"); end
    @(posedge clk); #1;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL mul_valid_pulse: got %b expected 0", bus.valid); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL mul_ready_after: got %b expected 1", bus.ready); end
    checks++; if (bus.result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_hold: got %h expected ffffffeb", bus.result); end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [9] = '{3'd3, 3'd1, 3'd2, 3'd0, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4};
    logic [31:0] as  [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd6, 32'd5, 32'd5,
                             32'h8000_0000, 32'h8000_0000, 32'd20};
    logic [31:0] bs  [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
`ifdef MULDIV_DIV_EN
    logic [31:0] er  [9] = '{32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd42, 32'hFFFF_FFFF, 32'd5,
                             32'h8000_0000, 32'd0, 32'd6};
    logic [3:0]  ef  [9] = '{4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b1001, 4'b1000, 4'b0101, 4'b0110, 4'b0000};
    int          el  [9] = '{LAT, LAT, LAT, LAT, 0, 0, 0, 0, LAT};
`else
    logic [31:0] er  [9] = '{32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd42, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [3:0]  ef  [9] = '{4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    int          el  [9] = '{LAT, LAT, LAT, LAT, 0, 0, 0, 0, 0};
`endif
    logic [31:0] res; logic [3:0] fl; int lat, vc; bit rok;
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], as[i], bs[i], res, fl, lat, rok, vc);
      checks++; if (res !== er[i]) begin errors++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, er[i]); end
      checks++; if (fl !== ef[i]) begin errors++; $display("FAIL directed_flags[%0d]: got %b expected %b", i, fl, ef[i]); end
      checks++; if (lat !== el[i]) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, el[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [5] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd0};
    logic [31:0] as  [5] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100, 32'd7};
    logic [31:0] bs  [5] = '{32'd3, 32'd3, 32'd7, 32'd7, 32'hFFFF_FFFD};
`ifdef MULDIV_DIV_EN
    logic [31:0] er  [5] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFEB};
    int          el  [5] = '{LAT, LAT, LAT, LAT, LAT};
`else
    logic [31:0] er  [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFEB};
    int          el  [5] = '{0, 0, 0, 0, LAT};
`endif
    logic [31:0] res; logic [3:0] fl; int lat, vc, prev_vc; bit rok;
    prev_vc = 0;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], res, fl, lat, rok, vc);
      checks++; if (res !== er[i]) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, res, er[i]); end
      checks++; if (!rok) begin errors++; $display("FAIL b2b_ready[%0d]: got wrong ready around request, expected high then low", i); end
      if (i > 0) begin
        checks++;
        if (vc - prev_vc !== el[i] + 1) begin
          errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles expected %0d", i, vc - prev_vc, el[i] + 1);
        end
      end
      prev_vc = vc;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start();
    int n;
    n = -1;
    bus.start = 1'b1; bus.op = 3'd0; bus.operand1 = 32'd1234567; bus.operand2 = 32'd89;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 3'd3; bus.operand1 = 32'hDEAD_BEEF; bus.operand2 = 32'h1234_5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 6; k <= 100; k++) begin
      if (bus.valid === 1'b1) begin n = k; break; end
      @(posedge clk); #1;
    end
    checks++; if (n !== LAT) begin errors++; $display("FAIL ignored_latency: got %0d expected %0d", n, LAT); end
    checks++; if (bus.result !== 32'd109876463) begin errors++; $display("FAIL ignored_result: got %h expected %h", bus.result, 32'd109876463); end
    checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL ignored_flags: got %b expected 0000", bus.flags); end
    @(posedge clk); #1;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ignored_no_second: got %b expected 0", bus.valid); end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    pulses = 0;
    bus.start = 1'b1; bus.operand1 = 32'd1000; bus.operand2 = 32'd7;
`ifdef MULDIV_DIV_EN
    bus.op = 3'd4;
`else
    bus.op = 3'd0;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", bus.ready); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL midrst_result: got %h expected 0", bus.result); end
    checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL midrst_flags: got %b expected 0000", bus.flags); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_valid: got %0d pulses expected 0", pulses); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL midrst_result_after: got %h expected 0", bus.result); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0] o; logic [31:0] a, b, res, er; logic [3:0] fl, ef; int lat, el, vc; bit rok;
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom);
      a = pick();
      b = pick();
      model(o, a, b, er, ef, el);
      run_op(o, a, b, res, fl, lat, rok, vc);
      checks++;
      if (res !== er || fl !== ef || lat !== el) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got res=%h flags=%b lat=%0d expected res=%h flags=%b lat=%0d",
                 i, o, a, b, res, fl, lat, er, ef, el);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_directed();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
